// File: rtl/addsub_pipe_nbit.sv
// Two-stage pipelined WIDTH-bit adder/subtractor with valid/ready flow,
// signed-overflow flag and saturating overflow counter.
// Ports: clk, rst_n (async low); A, B, Add_ctrl (0=add 1=sub), in_valid ->
//   in_ready; SUM, C_out, O, out_valid <- out_ready; ovf_clr -> ovf_cnt.
// Option: define ADDSUB_SAT_EN to clamp SUM on signed overflow.
module addsub_pipe_nbit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Add_ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             C_out,
  output logic             O,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam int H = WIDTH / 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [H-1:0]     s1_lo_q;
  logic             s1_c_q;
  logic [H-1:0]     s1_ahi_q;
  logic [H-1:0]     s1_bhi_q;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] bx;
  logic [H:0]       lo_sum;
  logic [H:0]       hi_sum;
  logic             in_xfer;
  logic             s2_en;
  logic             s1_move;
  logic             res_xfer;

  assign in_ready  = ~s1_valid_q | ~s2_valid_q | out_ready;
  assign out_valid = s2_valid_q;
  assign SUM       = sum_q;
  assign C_out     = cout_q;
  assign O         = o_q;
  assign ovf_cnt   = cnt_q;

  always_comb begin
    bx = B ^ {WIDTH{Add_ctrl}};
    lo_sum = {1'b0, A[H-1:0]} + {1'b0, bx[H-1:0]}
           + {{H{1'b0}}, Add_ctrl};
    hi_sum = {1'b0, s1_ahi_q} + {1'b0, s1_bhi_q}
           + {{H{1'b0}}, s1_c_q};

    in_xfer  = in_valid & in_ready;
    // stage 2 can take new data when empty or draining this cycle
    s2_en    = ~s2_valid_q | out_ready;
    s1_move  = s1_valid_q & s2_en;
    res_xfer = s2_valid_q & out_ready;

    s1_valid_d = in_xfer | (s1_valid_q & ~s2_en);
    s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;

    cout_d = hi_sum[H];
    o_d    = (s1_ahi_q[H-1] == s1_bhi_q[H-1])
           & (hi_sum[H-1] != s1_ahi_q[H-1]);
`ifdef ADDSUB_SAT_EN
    if (o_d)
      sum_d = {s1_ahi_q[H-1], {(WIDTH-1){~s1_ahi_q[H-1]}}};
    else
      sum_d = {hi_sum[H-1:0], s1_lo_q};
`else
    sum_d = {hi_sum[H-1:0], s1_lo_q};
`endif

    // clear wins over the old count but still counts a same-cycle overflow
    cnt_d = cnt_q;
    if (ovf_clr)
      cnt_d = (res_xfer & o_q) ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    else if (res_xfer & o_q & (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      o_q        <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      if (in_xfer) begin
        s1_lo_q  <= lo_sum[H-1:0];
        s1_c_q   <= lo_sum[H];
        s1_ahi_q <= A[WIDTH-1:H];
        s1_bhi_q <= bx[WIDTH-1:H];
      end
      if (s1_move) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        o_q    <= o_d;
      end
    end
  end

endmodule

// File: doc/addsub_pipe_nbit.md
ADDSUB_PIPE_NBIT -- requirements
Module: addsub_pipe_nbit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width; legal values are even and at least 4.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the overflow-counter width; the minimum is 1.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide; reset is asynchronous and active-low.
REQ-005 Port A SHALL be an input, WIDTH bits wide, carrying operand A.
REQ-006 Port B SHALL be an input, WIDTH bits wide, carrying operand B.
REQ-007 Port Add_ctrl SHALL be an input, 1 bit wide: 0 selects A+B, 1 selects A-B.
REQ-008 Port in_valid SHALL be an input, 1 bit wide, meaning operands are presented.
REQ-009 Port in_ready SHALL be an output, 1 bit wide, meaning the block can accept operands.
REQ-010 Port SUM SHALL be an output, WIDTH bits wide, carrying the result.
REQ-011 Port C_out SHALL be an output, 1 bit wide, carrying the carry out of the MSB.
REQ-012 Port O SHALL be an output, 1 bit wide, flagging two's-complement signed overflow.
REQ-013 Port out_valid SHALL be an output, 1 bit wide, meaning SUM, C_out and O are valid.
REQ-014 Port out_ready SHALL be an input, 1 bit wide, meaning the consumer accepts the result.
REQ-015 Port ovf_clr SHALL be an input, 1 bit wide, a synchronous clear of ovf_cnt.
REQ-016 Port ovf_cnt SHALL be an output, CNT_W bits wide, counting delivered results with O=1.

Function
REQ-017 Arithmetic SHALL be {C_out,SUM} = A + (B XOR {WIDTH{Add_ctrl}}) + Add_ctrl.
- In subtract mode, C_out=1 means no borrow.
REQ-018 O SHALL be (A[MSB] == B'[MSB]) AND (SUM[MSB] != A[MSB]), where B' is the post-inversion operand.
REQ-019 The datapath SHALL be a two-stage pipeline.
- Stage 1 registers the low-half sum, the low-half carry, and the raw high halves of A and B' plus Add_ctrl.
- Stage 2 registers the high-half sum, C_out and O.
REQ-020 An operand transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; a result transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-021 Latency SHALL be exactly 2 cycles from transfer edge to out_valid=1 when out_ready is held 1; throughput SHALL be one result per cycle.
REQ-022 in_ready SHALL equal NOT s1_valid OR NOT s2_valid OR out_ready.
- in_ready is combinational and has no path from in_valid.
REQ-023 While out_valid=1 and out_ready=0, SUM, C_out and O SHALL hold stable and no accepted operand SHALL be lost or duplicated.
REQ-024 A bubble SHALL collapse: stage 1 advances into an empty stage 2 even while out_ready=0.
REQ-025 ovf_cnt SHALL increment by 1 on each result transfer with O=1 (O as delivered, before any saturation), and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-026 If ovf_clr=1 and an overflowing result transfer occur in the same cycle, ovf_cnt SHALL become 1; ovf_clr alone SHALL set it to 0.
REQ-027 Operand values with in_valid=0 SHALL have no effect on state.

Reset
REQ-028 While rst_n=0, and asynchronously on its falling edge, the block SHALL force out_valid=0, all internal valid bits=0, SUM=0, C_out=0, O=0 and ovf_cnt=0.
REQ-029 in_ready SHALL be 1 during and immediately after reset.
REQ-030 Any in-flight operation SHALL be discarded by a reset applied mid-pipeline, and no result SHALL appear after release.
REQ-031 Reset deassertion SHALL be synchronous-safe: the first transfer is accepted on the first rising edge after rst_n rises.

Configuration
REQ-032 With macro ADDSUB_SAT_EN defined, when O=1 SUM SHALL be clamped.
- Clamp to 0111..1 when A[MSB]=0, or to 1000..0 when A[MSB]=1.
- C_out and O are unchanged.
REQ-033 Without ADDSUB_SAT_EN, SUM SHALL be the wrapped WIDTH-bit result and no clamp logic SHALL exist.

Verification
REQ-034 Reset check: WIDTH=16, rst_n low, then release -> out_valid=0, ovf_cnt=0, in_ready=1.
REQ-035 Add case: A=7FFF, B=0001, Add_ctrl=0, out_ready=1 -> 2 cycles later SUM=8000 (7FFF with SAT_EN), C_out=0, O=1, then ovf_cnt=1.
REQ-036 Subtract case: A=0000, B=0001, Add_ctrl=1 -> SUM=FFFF, C_out=0, O=0; A=0005, B=0003 -> SUM=0002, C_out=1, O=0.
REQ-037 Backpressure: stream 4 back-to-back operations with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, SUM stays stable, all 4 results arrive in order once out_ready=1.
REQ-038 Counter saturation: CNT_W=2 with 5 overflowing results -> ovf_cnt stays at 3; then ovf_clr together with an overflowing transfer -> ovf_cnt=1.
REQ-039 Mid-pipeline reset: assert rst_n=0 with both stages valid -> out_valid=0 immediately, and no stale result appears after release.
